// File: rtl/riscv_core_pkg.sv
// Shared core definitions for the branch-recovery slice: default geometry,
// the prediction-queue entry layout and a helper for its packed width.
package riscv_core_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int DEPTH_DEF = 4;

    // Entry layout at the default PC width; the packed vector stored in the
    // FIFO uses exactly this field order (MSB first).
    typedef struct packed {
        logic                is_branch;
        logic                predict;
        logic [PC_W_DEF-1:0] target;
        logic [PC_W_DEF-1:0] fallthru;
    } pred_entry_t;

    // Packed width of one entry for an arbitrary PC width.
    function automatic int entry_width(input int pc_w);
        return (2 * pc_w) + 2;
    endfunction

endpackage

// File: rtl/branch_recovery_pred_fifo.sv
// pred_fifo: DEPTH-entry synchronous circular FIFO with single-cycle clear.
// A push while full is dropped even if a pop happens in the same cycle,
// because fullness is judged from registered occupancy only.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    assign rdata     = mem_r[head_r];
    assign count     = count_r;

    // Pointer and occupancy update; clear wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; written at the tail on an accepted, non-cleared push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !clr) begin
            mem_r[tail_r] <= wdata;
        end
    end

endmodule

// File: rtl/branch_recovery.sv
// branch_recovery: in-order queue of outstanding control-flow predictions.
// The oldest entry is popped on resolve; a direction mismatch on a branch
// issues a registered redirect and discards all younger wrong-path entries.
// Every popped conditional branch produces a predictor training strobe.
// Optional build macro: BRANCH_STATS_EN adds stat_resolved / stat_mispred.
module branch_recovery
    import riscv_core_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    input  logic                    push_is_branch,
    input  logic                    push_predict,
    input  logic [PC_W-1:0]         push_target,
    input  logic [PC_W-1:0]         push_fallthru,
    output logic                    push_ready,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    input  logic                    flush,
    output logic                    redirect_valid,
    output logic [PC_W-1:0]         redirect_pc,
    output logic                    bp_update,
    output logic                    bp_result,
    output logic [$clog2(DEPTH):0]  count
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispred
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int E_W   = entry_width(PC_W);

    logic [E_W-1:0]   wdata_s;
    logic [E_W-1:0]   head_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             head_is_branch_s;
    logic             head_predict_s;
    logic [PC_W-1:0]  head_target_s;
    logic [PC_W-1:0]  head_fallthru_s;
    logic             pop_s;
    logic             mispred_s;
    logic             clear_s;
    logic             fifo_push_s;
    logic             train_s;
    logic [PC_W-1:0]  redirect_pc_s;

    logic             redirect_valid_r;
    logic [PC_W-1:0]  redirect_pc_r;
    logic             bp_update_r;
    logic             bp_result_r;

    assign wdata_s = {push_is_branch, push_predict, push_target, push_fallthru};

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (E_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_s),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s)
    );

    // Resolve decode: pop, mispredict detection, queue clear and push gating.
    always_comb begin
        head_is_branch_s = head_s[E_W-1];
        head_predict_s   = head_s[E_W-2];
        head_target_s    = head_s[2*PC_W-1:PC_W];
        head_fallthru_s  = head_s[PC_W-1:0];
        pop_s            = resolve_valid && (count_s != {CNT_W{1'b0}});
        train_s          = pop_s && head_is_branch_s;
        mispred_s        = train_s && (resolve_taken != head_predict_s);
        clear_s          = flush || mispred_s;
        fifo_push_s      = push_valid && !clear_s;
        redirect_pc_s    = {PC_W{1'b0}};
        if (mispred_s) begin
            if (resolve_taken) begin
                redirect_pc_s = head_target_s;
            end else begin
                redirect_pc_s = head_fallthru_s;
            end
        end else begin
            redirect_pc_s = {PC_W{1'b0}};
        end
    end

    // Registered redirect and training strobes, one cycle after the resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {PC_W{1'b0}};
            bp_update_r      <= 1'b0;
            bp_result_r      <= 1'b0;
        end else begin
            redirect_valid_r <= mispred_s;
            redirect_pc_r    <= redirect_pc_s;
            bp_update_r      <= train_s;
            bp_result_r      <= train_s && resolve_taken;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign bp_update      = bp_update_r;
    assign bp_result      = bp_result_r;
    assign push_ready     = !full_s;
    assign count          = count_s;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved_r;
    logic [31:0] stat_mispred_r;

    // Free-running resolved-branch and mispredict counters (wrap at 2^32).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_r <= 32'd0;
            stat_mispred_r  <= 32'd0;
        end else begin
            if (train_s) begin
                stat_resolved_r <= stat_resolved_r + 32'd1;
            end
            if (mispred_s) begin
                stat_mispred_r <= stat_mispred_r + 32'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_r;
    assign stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_branch_recovery.sv
// Testbench for branch_recovery: directed scenarios then randomized traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_branch_recovery;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid, push_is_branch, push_predict;
    logic [PC_W-1:0]   push_target, push_fallthru;
    logic              push_ready;
    logic              resolve_valid, resolve_taken, flush;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              bp_update, bp_result;
    logic [2:0]        count;
`ifdef BRANCH_STATS_EN
    logic [31:0]       stat_resolved, stat_mispred;
`endif

    branch_recovery #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_is_branch (push_is_branch),
        .push_predict   (push_predict),
        .push_target    (push_target),
        .push_fallthru  (push_fallthru),
        .push_ready     (push_ready),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bp_update      (bp_update),
        .bp_result      (bp_result),
        .count          (count)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          br;
        bit          pred;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    typedef struct {
        int          cyc;
        bit          rv;
        logic [31:0] pc;
        bit          upd;
        bit          res;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_resolved = 0;
    int   m_mispred = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a redirect or training strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid || bp_update) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got rv=%0b upd=%0b pc=0x%0h, expected none (cycle %0d)",
                             redirect_valid, bp_update, redirect_pc, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_cycle", cyc, mon_e.cyc);
                    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.rv});
                    check("redirect_pc", redirect_pc, mon_e.pc);
                    check("bp_update", {31'd0, bp_update}, {31'd0, mon_e.upd});
                    check("bp_result", {31'd0, bp_result}, {31'd0, mon_e.res});
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missing_output_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus: check registered state, drive inputs, advance the model.
    task automatic step(input bit pv, input bit br, input bit pred, input logic [31:0] tgt,
                        input logic [31:0] ft, input bit rv, input bit tk, input bit fl);
        bit   ready;
        bit   pop;
        bit   mis;
        ent_t e;
        @(negedge clk);
        check("count", {29'd0, count}, mq.size());
        check("push_ready", {31'd0, push_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
`ifdef BRANCH_STATS_EN
        check("stat_resolved", stat_resolved, m_resolved);
        check("stat_mispred", stat_mispred, m_mispred);
`endif
        push_valid     = pv;
        push_is_branch = br;
        push_predict   = pred;
        push_target    = tgt;
        push_fallthru  = ft;
        resolve_valid  = rv;
        resolve_taken  = tk;
        flush          = fl;
        ready = (mq.size() < DEPTH);
        pop   = rv && (mq.size() > 0);
        mis   = 1'b0;
        if (pop) begin
            e   = mq[0];
            mis = e.br && (tk != e.pred);
            if (e.br) begin
                sb.push_back('{cyc + 1, mis, mis ? (tk ? e.tgt : e.ft) : 32'd0, 1'b1, tk});
                m_resolved++;
            end
            if (mis) m_mispred++;
        end
        if (fl || mis) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (pv && ready) mq.push_back('{br, pred, tgt, ft});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          r_pv, r_br, r_pred, r_rv, r_tk, r_fl;
        logic [31:0] r_tgt;
        rst = 1'b1;
        push_valid = 1'b0; push_is_branch = 1'b0; push_predict = 1'b0;
        push_target = 32'd0; push_fallthru = 32'd0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_bp_update", {31'd0, bp_update}, 32'd0);
        check("reset_bp_result", {31'd0, bp_result}, 32'd0);
        rst = 1'b0;

        // Correctly predicted taken branch: training only.
        step(1'b1, 1'b1, 1'b1, 32'h180, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(); idle();

        // Mispredict on oldest of three; same-cycle push is discarded.
        step(1'b1, 1'b1, 1'b0, 32'h200, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h300, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h400, 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h900, 32'h904, 1'b1, 1'b1, 1'b0);
        idle(); idle();

        // Fill, drop a push while full, then pop+push while full.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h5000, 32'h5004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h6000, 32'h6004, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        idle();

        // JAL never mispredicts and never trains.
        step(1'b1, 1'b0, 1'b1, 32'h700, 32'h704, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle();

        // Resolve on empty queue; flush with two entries and a simultaneous push.
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h800, 32'h804, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h810, 32'h814, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h820, 32'h824, 1'b0, 1'b0, 1'b1);
        idle(); idle();

        // Reset asserted just after a mispredicting resolve edge.
        step(1'b1, 1'b1, 1'b0, 32'hA00, 32'hA04, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_bp_update", {31'd0, bp_update}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        sb.delete();
        mq.delete();
        m_resolved = 0;
        m_mispred  = 0;
`ifdef BRANCH_STATS_EN
        check("rst_stat_resolved", stat_resolved, 32'd0);
        check("rst_stat_mispred", stat_mispred, 32'd0);
`endif
        push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic; resolves usually agree with the oldest prediction.
        for (int n = 0; n < 600; n++) begin
            r_pv   = ($urandom_range(0, 99) < 60);
            r_br   = ($urandom_range(0, 3) != 0);
            r_pred = 1'($urandom);
            r_tgt  = $urandom & 32'hFFFF_FFFC;
            r_rv   = ($urandom_range(0, 99) < 50);
            r_fl   = ($urandom_range(0, 99) < 4);
            if (mq.size() > 0) begin
                r_tk = ($urandom_range(0, 3) != 0) ? mq[0].pred : ~mq[0].pred;
            end else begin
                r_tk = 1'($urandom);
            end
            step(r_pv, r_br, r_pred, r_tgt, r_tgt + 32'd4, r_rv, r_tk, r_fl);
        end
        idle(); idle(); idle();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
